// File: rtl/mul_hybrid_mac.sv
// Pipelined multi-precision radix-4 Booth MAC: 1/2/4 signed lanes per beat,
// per-lane accumulation over a group closed by in_last, one packed psum per group.
module mul_hybrid_mac #(
  parameter int DATA_W = 8,
  parameter int PSUM_W = 24,
  parameter int CNT_W  = 8,
  localparam int QW    = $clog2(DATA_W) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ifmap,
  input  logic [DATA_W-1:0] filter,
  input  logic [QW-1:0]     quant_size,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PSUM_W-1:0] psum,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_err
);

  localparam int LW1 = DATA_W;
  localparam int LW2 = DATA_W / 2;
  localparam int LW4 = DATA_W / 4;
  localparam int AW2 = PSUM_W / 2;
  localparam int AW4 = PSUM_W / 4;

  typedef enum logic [1:0] {MODE_L1, MODE_L2, MODE_L4} mode_e;

  // Signed m * r for a w-bit filter lane; r must arrive sign-extended to DATA_W.
  function automatic logic signed [PSUM_W-1:0] booth_mul(
    input logic signed [DATA_W-1:0] m,
    input logic signed [DATA_W-1:0] r,
    input int w
  );
    logic signed [PSUM_W-1:0] acc, mx, pp;
    logic [DATA_W:0] rx;
    logic [2:0] dig;
    acc = '0;
    mx  = PSUM_W'(m);
    rx  = {r, 1'b0};
    for (int i = 0; i < DATA_W / 2; i++) begin
      dig = rx[2*i +: 3];
      case (dig)
        3'b001, 3'b010: pp = mx;
        3'b011:         pp = mx <<< 1;
        3'b100:         pp = -(mx <<< 1);
        3'b101, 3'b110: pp = -mx;
        default:        pp = '0;
      endcase
      if (i < w / 2) acc = acc + (pp <<< (2 * i));
    end
    return acc;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic              in_first_q, in_first_d;
  mode_e             grp_mode_q, grp_mode_d;
  logic              grp_err_q, grp_err_d;
  logic              vld_p1_q, vld_p1_d;
  logic              last_p1_q, last_p1_d;
  mode_e             mode_p1_q, mode_p1_d;
  logic              err_p1_q, err_p1_d;
  logic [PSUM_W-1:0] prod_p1_q, prod_p1_d;
  logic [PSUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_acc_q, err_acc_d;
  logic              acc_first_q, acc_first_d;
  logic              out_valid_q, out_valid_d;
  logic [PSUM_W-1:0] psum_q, psum_d;
  logic [CNT_W-1:0]  out_count_q, out_count_d;
  logic              out_err_q, out_err_d;

  mode_e                    dec_mode, beat_mode;
  logic                     dec_err, beat_err;
  logic                     stall, accept, s2_go;
  logic [PSUM_W-1:0]        lane_prod, acc_upd;
  logic [CNT_W-1:0]         cnt_upd;
  logic                     err_upd;
  logic signed [DATA_W-1:0] op_a, op_b;
  logic signed [PSUM_W-1:0] p;

  // Input side: mode decode and held-per-group mode
  always_comb begin
    dec_mode = MODE_L1;
    dec_err  = 1'b0;
    if (quant_size == QW'(LW1))      dec_mode = MODE_L1;
    else if (quant_size == QW'(LW2)) dec_mode = MODE_L2;
    else if (quant_size == QW'(LW4)) dec_mode = MODE_L4;
    else                             dec_err  = 1'b1;
    beat_mode = in_first_q ? dec_mode : grp_mode_q;
    beat_err  = in_first_q ? dec_err  : grp_err_q;
  end

  // Lane products, each sign-extended and packed into its accumulator slot
  always_comb begin
    lane_prod = '0;
    op_a      = '0;
    op_b      = '0;
    p         = '0;
    case (beat_mode)
      MODE_L2: begin
        for (int k = 0; k < 2; k++) begin
          op_a = {{(DATA_W-LW2){ifmap[k*LW2+LW2-1]}},  ifmap[k*LW2 +: LW2]};
          op_b = {{(DATA_W-LW2){filter[k*LW2+LW2-1]}}, filter[k*LW2 +: LW2]};
          p    = booth_mul(op_a, op_b, LW2);
          lane_prod[k*AW2 +: AW2] = p[AW2-1:0];
        end
      end
      MODE_L4: begin
        for (int k = 0; k < 4; k++) begin
          op_a = {{(DATA_W-LW4){ifmap[k*LW4+LW4-1]}},  ifmap[k*LW4 +: LW4]};
          op_b = {{(DATA_W-LW4){filter[k*LW4+LW4-1]}}, filter[k*LW4 +: LW4]};
          p    = booth_mul(op_a, op_b, LW4);
          lane_prod[k*AW4 +: AW4] = p[AW4-1:0];
        end
      end
      default: begin
        p         = booth_mul(ifmap, filter, LW1);
        lane_prod = p;
      end
    endcase
    if (beat_err) lane_prod = '0;
  end

  assign stall    = vld_p1_q && last_p1_q && out_valid_q && !out_ready;
  assign in_ready = !rst && !stall;
  assign accept   = in_valid && in_ready;
  assign s2_go    = vld_p1_q && !stall;

  // Accumulator update for the beat held in S1, wrapping per lane
  always_comb begin
    acc_upd = '0;
    case (mode_p1_q)
      MODE_L2:
        for (int k = 0; k < 2; k++)
          acc_upd[k*AW2 +: AW2] = (acc_first_q ? '0 : acc_q[k*AW2 +: AW2])
                                  + prod_p1_q[k*AW2 +: AW2];
      MODE_L4:
        for (int k = 0; k < 4; k++)
          acc_upd[k*AW4 +: AW4] = (acc_first_q ? '0 : acc_q[k*AW4 +: AW4])
                                  + prod_p1_q[k*AW4 +: AW4];
      default:
        acc_upd = (acc_first_q ? '0 : acc_q) + prod_p1_q;
    endcase
    cnt_upd = acc_first_q ? CNT_W'(1) : sat_inc(cnt_q);
    err_upd = acc_first_q ? err_p1_q : (err_acc_q | err_p1_q);
  end

  always_comb begin
    in_first_d = in_first_q;
    grp_mode_d = grp_mode_q;
    grp_err_d  = grp_err_q;
    if (accept) begin
      in_first_d = in_last;
      if (in_first_q) begin
        grp_mode_d = dec_mode;
        grp_err_d  = dec_err;
      end
    end

    vld_p1_d  = vld_p1_q;
    last_p1_d = last_p1_q;
    mode_p1_d = mode_p1_q;
    err_p1_d  = err_p1_q;
    prod_p1_d = prod_p1_q;
    if (!stall) begin
      vld_p1_d = accept;
      if (accept) begin
        last_p1_d = in_last;
        mode_p1_d = beat_mode;
        err_p1_d  = beat_err;
        prod_p1_d = lane_prod;
      end
    end

    acc_d       = acc_q;
    cnt_d       = cnt_q;
    err_acc_d   = err_acc_q;
    acc_first_d = acc_first_q;
    if (s2_go) begin
      acc_d       = acc_upd;
      cnt_d       = cnt_upd;
      err_acc_d   = err_upd;
      acc_first_d = last_p1_q;
    end

    out_valid_d = out_valid_q;
    psum_d      = psum_q;
    out_count_d = out_count_q;
    out_err_d   = out_err_q;
    if (out_valid_q && out_ready) out_valid_d = 1'b0;
    if (s2_go && last_p1_q) begin
      out_valid_d = 1'b1;
      psum_d      = acc_upd;
      out_count_d = cnt_upd;
      out_err_d   = err_upd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_first_q  <= 1'b1;
      grp_mode_q  <= MODE_L1;
      grp_err_q   <= 1'b0;
      vld_p1_q    <= 1'b0;
      last_p1_q   <= 1'b0;
      mode_p1_q   <= MODE_L1;
      err_p1_q    <= 1'b0;
      prod_p1_q   <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      err_acc_q   <= 1'b0;
      acc_first_q <= 1'b1;
      out_valid_q <= 1'b0;
      psum_q      <= '0;
      out_count_q <= '0;
      out_err_q   <= 1'b0;
    end else begin
      in_first_q  <= in_first_d;
      grp_mode_q  <= grp_mode_d;
      grp_err_q   <= grp_err_d;
      vld_p1_q    <= vld_p1_d;
      last_p1_q   <= last_p1_d;
      mode_p1_q   <= mode_p1_d;
      err_p1_q    <= err_p1_d;
      prod_p1_q   <= prod_p1_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      err_acc_q   <= err_acc_d;
      acc_first_q <= acc_first_d;
      out_valid_q <= out_valid_d;
      psum_q      <= psum_d;
      out_count_q <= out_count_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign psum      = psum_q;
  assign out_count = out_count_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_mul_hybrid_mac.sv
// Directed + small random bench for mul_hybrid_mac with an expected-result queue.
module tb_mul_hybrid_mac;
  localparam int DATA_W = 8;
  localparam int PSUM_W = 24;
  localparam int CNT_W  = 8;
  localparam int QW     = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] ifmap = '0;
  logic [DATA_W-1:0] filter = '0;
  logic [QW-1:0]     quant_size = 4'd8;
  logic              in_last = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [PSUM_W-1:0] psum;
  logic [CNT_W-1:0]  out_count;
  logic              out_err;

  always #5 clk = ~clk;

  mul_hybrid_mac #(.DATA_W(DATA_W), .PSUM_W(PSUM_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ifmap(ifmap), .filter(filter), .quant_size(quant_size), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .psum(psum),
    .out_count(out_count), .out_err(out_err)
  );

  typedef struct packed {
    logic [23:0] psum;
    logic [7:0]  cnt;
    logic        err;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int n_vec  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [23:0] p, input logic [7:0] c, input logic e);
    q.push_back('{psum: p, cnt: c, err: e});
  endtask

  // Drive one beat and wait (bounded) for it to be accepted.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] qs,
                      input logic last);
    int n;
    logic took;
    ifmap = a; filter = b; quant_size = qs; in_last = last; in_valid = 1'b1;
    n = 0;
    took = 1'b0;
    while (!took && n < 100) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk);
      n++;
    end
    #1 in_valid = 1'b0;
    if (!took) check("accept_timeout", 32'(took), 32'd1);
  endtask

  // Random legal group with a behavioural lane model for the expected psum.
  task automatic rand_group(input int lanes, input int len);
    int acc[4];
    int w, aw, x, y;
    logic [7:0] a, f;
    logic [23:0] p;
    logic [3:0] qs;
    w = 8 / lanes;
    aw = 24 / lanes;
    qs = 4'(w);
    for (int i = 0; i < len; i++) begin
      a = 8'($urandom);
      f = 8'($urandom);
      for (int k = 0; k < lanes; k++) begin
        x = (int'(a) >> (k * w)) & ((1 << w) - 1);
        if (x >= (1 << (w - 1))) x -= (1 << w);
        y = (int'(f) >> (k * w)) & ((1 << w) - 1);
        if (y >= (1 << (w - 1))) y -= (1 << w);
        acc[k] = (i == 0) ? x * y : acc[k] + x * y;
        acc[k] = acc[k] & ((1 << aw) - 1);
      end
      if (i == len - 1) begin
        p = '0;
        for (int k = 0; k < lanes; k++) p = p | (24'(acc[k]) << (k * aw));
        push_exp(p, 8'(len), 1'b0);
      end
      send(a, f, qs, i == len - 1);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_out", 32'(out_valid), 32'd0);
      end else begin
        mon_e = q.pop_front();
        check("psum", 32'(psum), 32'(mon_e.psum));
        check("out_count", 32'(out_count), 32'(mon_e.cnt));
        check("out_err", 32'(out_err), 32'(mon_e.err));
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_psum", 32'(psum), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    sync();
    rst = 1'b0;
    sync();

    // 8-bit single beat, most negative operands, latency t+2
    push_exp(24'h004000, 8'd1, 1'b0);
    send(8'h80, 8'h80, 4'd8, 1'b1);
    @(negedge clk);
    check("lat_t1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("lat_t2_valid", 32'(out_valid), 32'd1);
    sync();

    // 8-bit three beats; later-beat quant_size values are ignored
    send(8'd10, 8'd20, 4'd8, 1'b0);
    send(8'hFB, 8'd7, 4'd3, 1'b0);
    push_exp(24'h003FA6, 8'd3, 1'b0);
    send(8'd127, 8'd127, 4'd4, 1'b1);

    // 4-bit two lanes
    push_exp(24'hFC8FF9, 8'd1, 1'b0);
    send(8'h7F, 8'h87, 4'd4, 1'b1);

    // 2-bit four lanes: wrap at 16 beats, 60 per lane at 15 beats
    for (int i = 0; i < 16; i++) begin
      if (i == 15) push_exp(24'h000000, 8'd16, 1'b0);
      send(8'hAA, 8'hAA, 4'd2, i == 15);
    end
    for (int i = 0; i < 15; i++) begin
      if (i == 14) push_exp(24'hF3CF3C, 8'd15, 1'b0);
      send(8'hAA, 8'hAA, 4'd2, i == 14);
    end

    // Backpressure: result A waits while group B fills and then stalls
    repeat (4) sync();
    out_ready = 1'b0;
    push_exp(24'h00000C, 8'd1, 1'b0);
    send(8'd3, 8'd4, 4'd8, 1'b1);
    repeat (3) sync();
    @(negedge clk);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_psum_a", 32'(psum), 32'h00000C);
    sync();
    send(8'd2, 8'd5, 4'd8, 1'b0);
    check("bp_ready_nonlast", 32'(in_ready), 32'd1);
    push_exp(24'hFFFFF8, 8'd2, 1'b0);
    send(8'hFD, 8'd6, 4'd8, 1'b1);
    @(negedge clk);
    check("bp_stall_ready", 32'(in_ready), 32'd0);
    check("bp_hold_psum", 32'(psum), 32'h00000C);
    check("bp_hold_count", 32'(out_count), 32'd1);
    sync();
    out_ready = 1'b1;
    repeat (3) sync();

    // Illegal mode: single beat, then sticky over a two-beat group
    push_exp(24'h000000, 8'd1, 1'b1);
    send(8'h55, 8'h33, 4'd3, 1'b1);
    send(8'h55, 8'h33, 4'd3, 1'b0);
    push_exp(24'h000000, 8'd2, 1'b1);
    send(8'h12, 8'h34, 4'd8, 1'b1);

    // Reset with a pending result and a partial group
    repeat (4) sync();
    out_ready = 1'b0;
    send(8'd2, 8'd2, 4'd8, 1'b1);
    repeat (3) sync();
    send(8'd9, 8'd9, 4'd8, 1'b0);
    send(8'd3, 8'd3, 4'd8, 1'b0);
    rst = 1'b1;
    q.delete();
    sync();
    sync();
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;
    sync();
    push_exp(24'hFFFFD6, 8'd1, 1'b0);
    send(8'd6, 8'hF9, 4'd8, 1'b1);

    // Beat counter saturation
    for (int i = 0; i < 300; i++) begin
      if (i == 299) push_exp(24'h00012C, 8'd255, 1'b0);
      send(8'd1, 8'd1, 4'd8, i == 299);
    end

    // Random groups in every legal mode
    for (int g = 0; g < 9; g++) rand_group(1 << (g % 3), 1 + int'($urandom_range(0, 4)));

    n = 0;
    while (q.size() != 0 && n < 100) begin
      sync();
      n++;
    end
    check("drain_queue", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
